// File: rtl/i2c_init_sequencer.sv
// Walks a table of (addr, data) register writes and issues one i2c_master start per entry,
// with a programmable idle gap between entries; reports done, or error on start-accept timeout.
module i2c_init_sequencer #(
  parameter int                     NUM_CMDS     = 8,
  parameter string                  INIT_FILE    = "i2c_init.hex",
  parameter logic [NUM_CMDS*16-1:0] INIT_TABLE   = '0,
  parameter int                     DELAY_CYCLES = 1000,
  parameter int                     TIMEOUT      = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          go,
  input  logic                          i2c_ready,
  output logic                          i2c_start,
  output logic [6:0]                    i2c_addr,
  output logic [7:0]                    i2c_data,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(NUM_CMDS+1)-1:0] index
);

  localparam int IW    = $clog2(NUM_CMDS + 1);
  localparam int DEPTH = 1 << IW;
  localparam int GW    = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DELAY = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Words past the table read as end markers.
  logic [15:0] rom [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++)
      rom[i] = (i < NUM_CMDS) ? INIT_TABLE[i*16 +: 16] : 16'h8000;
  end

  logic [2:0]    state;
  logic          fetch_phase;
  logic [15:0]   entry;
  logic [TW-1:0] req_cnt;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    entry <= rom[index];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      fetch_phase <= 1'b0;
      i2c_start   <= 1'b0;
      i2c_addr    <= '0;
      i2c_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      index       <= '0;
      req_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            index       <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
            fetch_phase <= 1'b0;
            state       <= S_FETCH;
          end
        end
        // First cycle lets the registered read catch up with a freshly updated index.
        S_FETCH: begin
          if (!fetch_phase) begin
            fetch_phase <= 1'b1;
          end else begin
            fetch_phase <= 1'b0;
            if (index == IW'(NUM_CMDS) || entry[15]) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              i2c_addr  <= entry[14:8];
              i2c_data  <= entry[7:0];
              i2c_start <= 1'b1;
              req_cnt   <= '0;
              state     <= S_REQ;
            end
          end
        end
        // Start stays up while ready is high: a start landing in the master's stop cycle is dropped.
        S_REQ: begin
          if (!i2c_ready) begin
            i2c_start <= 1'b0;
            state     <= S_WAIT;
          end else if (req_cnt == TW'(TIMEOUT - 1)) begin
            i2c_start <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i2c_ready) begin
            if (DELAY_CYCLES == 0) begin
              index <= index + 1'b1;
              state <= S_FETCH;
            end else begin
              gap_cnt <= GW'(DELAY_CYCLES);
              state   <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (gap_cnt == GW'(1)) begin
            index <= index + 1'b1;
            state <= S_FETCH;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Two sequencers (end-marked table with gap, full table without gap) driven by a randomized
// behavioural i2c master and checked against a table-walking reference model.
module tb_i2c_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [1:0] go = 2'b00;
  logic [1:0] mode = 2'b00;
  logic [1:0] force_ready = 2'b11;
  logic [1:0] model_ready = 2'b11;
  logic [1:0] ready, start, busy, done, error;
  logic [6:0] addr [2];
  logic [7:0] data [2];
  logic [3:0] index_a;
  logic [2:0] index_b;

  assign ready = (mode & model_ready) | (~mode & force_ready);

  i2c_init_sequencer #(
    .NUM_CMDS(8), .INIT_FILE(""), .DELAY_CYCLES(4), .TIMEOUT(64),
    .INIT_TABLE({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h5801, 16'h5830})
  ) dut_a (
    .clk(clk), .reset(reset), .go(go[0]), .i2c_ready(ready[0]), .i2c_start(start[0]),
    .i2c_addr(addr[0]), .i2c_data(data[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .index(index_a)
  );

  i2c_init_sequencer #(
    .NUM_CMDS(4), .INIT_FILE(""), .DELAY_CYCLES(0), .TIMEOUT(64),
    .INIT_TABLE({16'h0CFF, 16'h7F00, 16'h2B3D, 16'h1A5C})
  ) dut_b (
    .clk(clk), .reset(reset), .go(go[1]), .i2c_ready(ready[1]), .i2c_start(start[1]),
    .i2c_addr(addr[1]), .i2c_data(data[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .index(index_b)
  );

  logic [15:0] tbl_a [8] = '{16'h5830, 16'h5801, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] tbl_b [4] = '{16'h1A5C, 16'h2B3D, 16'h7F00, 16'h0CFF};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural master: accepts a start when idle, stays busy 1..6 cycles, then may ignore
  // start for 0..3 cycles while ready is high (stop-cycle behaviour).
  int          busy_left [2] = '{0, 0};
  int          holdoff   [2] = '{0, 0};
  bit          just_acc  [2] = '{0, 0};
  bit          prev_start[2] = '{0, 0};
  logic [6:0]  prev_addr [2];
  logic [7:0]  prev_data [2];
  int          end_cyc   [2] = '{0, 0};
  int          ntx       [2] = '{0, 0};
  int          late      [2] = '{0, 0};
  int          lost      [2] = '{0, 0};
  int          unstable  [2] = '{0, 0};
  int          gapviol   [2] = '{0, 0};
  logic [14:0] rec0 [$];
  logic [14:0] rec1 [$];

  function automatic int gap_of(input int u);
    return (u == 0) ? 4 : 0;
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset || !mode[u]) begin
        busy_left[u] = 0;
        holdoff[u] = 0;
        model_ready[u] = 1'b1;
        just_acc[u] = 1'b0;
      end else begin
        if (prev_start[u] && !start[u] && !just_acc[u]) lost[u]++;
        if (prev_start[u] && start[u] && (addr[u] !== prev_addr[u] || data[u] !== prev_data[u]))
          unstable[u]++;
        if (busy_left[u] > 0) begin
          if (just_acc[u] && start[u] !== 1'b0) late[u]++;
          just_acc[u] = 1'b0;
          busy_left[u]--;
          if (busy_left[u] == 0) begin
            model_ready[u] = 1'b1;
            end_cyc[u] = cyc;
            holdoff[u] = $urandom_range(0, 3);
          end
        end else if (start[u]) begin
          if (holdoff[u] > 0) begin
            holdoff[u]--;
          end else begin
            if (u == 0) rec0.push_back({addr[u], data[u]});
            else        rec1.push_back({addr[u], data[u]});
            $display("tx dut=%0d cycle=%0d addr=0x%02h data=0x%02h", u, cyc, addr[u], data[u]);
            if (ntx[u] > 0 && cyc - end_cyc[u] < gap_of(u)) gapviol[u]++;
            ntx[u]++;
            busy_left[u] = $urandom_range(1, 6);
            model_ready[u] = 1'b0;
            just_acc[u] = 1'b1;
          end
        end
      end
      prev_start[u] = start[u];
      prev_addr[u] = addr[u];
      prev_data[u] = data[u];
    end
  end

  // Reference: writes are the entries before the first end marker or the table end.
  logic [14:0] exp_q [$];
  int          exp_idx;

  task automatic build_expect(input int u);
    int n;
    bit stop;
    logic [15:0] w;
    exp_q.delete();
    n = (u == 0) ? 8 : 4;
    exp_idx = n;
    stop = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!stop) begin
        if (u == 0) w = tbl_a[i];
        else        w = tbl_b[i];
        if (w[15]) begin
          stop = 1'b1;
          exp_idx = i;
        end else begin
          exp_q.push_back(w[14:0]);
        end
      end
    end
  endtask

  function automatic int idx_of(input int u);
    return (u == 0) ? int'(index_a) : int'(index_b);
  endfunction

  function automatic int rec_size(input int u);
    return (u == 0) ? rec0.size() : rec1.size();
  endfunction

  function automatic logic [14:0] rec_at(input int u, input int k);
    return (u == 0) ? rec0[k] : rec1[k];
  endfunction

  task automatic pulse_go(input int u);
    @(negedge clk);
    go[u] = 1'b1;
    @(posedge clk);
    #1;
    go[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done[u]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      total++; if (start[u] !== 1'b0) begin bad++; $display("FAIL %s start dut=%0d got=%b want=0", tag, u, start[u]); end
      total++; if (busy[u]  !== 1'b0) begin bad++; $display("FAIL %s busy dut=%0d got=%b want=0", tag, u, busy[u]); end
      total++; if (done[u]  !== 1'b0) begin bad++; $display("FAIL %s done dut=%0d got=%b want=0", tag, u, done[u]); end
      total++; if (error[u] !== 1'b0) begin bad++; $display("FAIL %s error dut=%0d got=%b want=0", tag, u, error[u]); end
      total++; if (addr[u]  !== 7'h00) begin bad++; $display("FAIL %s addr dut=%0d got=%h want=0", tag, u, addr[u]); end
      total++; if (data[u]  !== 8'h00) begin bad++; $display("FAIL %s data dut=%0d got=%h want=0", tag, u, data[u]); end
      total++; if (idx_of(u) != 0) begin bad++; $display("FAIL %s index dut=%0d got=%0d want=0", tag, u, idx_of(u)); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sequence(input int u, input bit poke_go);
    int base, l0, lo0, us0, g0;
    bit ok;
    base = rec_size(u);
    l0 = late[u]; lo0 = lost[u]; us0 = unstable[u]; g0 = gapviol[u];
    mode[u] = 1'b1;
    build_expect(u);
    pulse_go(u);
    total++; if (busy[u] !== 1'b1) begin bad++; $display("FAIL seq%0d busy_after_go got=%b want=1", u, busy[u]); end
    total++; if (done[u] !== 1'b0) begin bad++; $display("FAIL seq%0d done_cleared got=%b want=0", u, done[u]); end
    @(posedge clk); #1;
    total++; if (start[u] !== 1'b0) begin bad++; $display("FAIL seq%0d start_at_1 got=%b want=0", u, start[u]); end
    @(posedge clk); #1;
    total++; if (start[u] !== 1'b1) begin bad++; $display("FAIL seq%0d start_at_2 got=%b want=1", u, start[u]); end
    total++; if ({addr[u], data[u]} !== exp_q[0]) begin
      bad++; $display("FAIL seq%0d first_entry got=%h want=%h", u, {addr[u], data[u]}, exp_q[0]);
    end
    if (poke_go) begin
      pulse_go(u);
      repeat (2) @(posedge clk);
      pulse_go(u);
    end
    wait_done(u, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL seq%0d done_timeout got=0 want=1", u); end
    total++; if (error[u] !== 1'b0) begin bad++; $display("FAIL seq%0d error got=%b want=0", u, error[u]); end
    total++; if (busy[u] !== 1'b0) begin bad++; $display("FAIL seq%0d busy_at_done got=%b want=0", u, busy[u]); end
    total++; if (idx_of(u) != exp_idx) begin bad++; $display("FAIL seq%0d index got=%0d want=%0d", u, idx_of(u), exp_idx); end
    total++;
    if (rec_size(u) - base != exp_q.size()) begin
      bad++; $display("FAIL seq%0d tx_count got=%0d want=%0d", u, rec_size(u) - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        total++;
        if (rec_at(u, base + k) !== exp_q[k]) begin
          bad++; $display("FAIL seq%0d tx%0d got=%h want=%h", u, k, rec_at(u, base + k), exp_q[k]);
        end
      end
    end
    total++; if (late[u] != l0) begin bad++; $display("FAIL seq%0d late_drop got=%0d want=0", u, late[u] - l0); end
    total++; if (lost[u] != lo0) begin bad++; $display("FAIL seq%0d lost_start got=%0d want=0", u, lost[u] - lo0); end
    total++; if (unstable[u] != us0) begin bad++; $display("FAIL seq%0d unstable got=%0d want=0", u, unstable[u] - us0); end
    total++; if (gapviol[u] != g0) begin bad++; $display("FAIL seq%0d short_gap got=%0d want=0", u, gapviol[u] - g0); end
  endtask

  task automatic test_stop_hold();
    int k, base;
    bit ok;
    mode[0] = 1'b0;
    force_ready[0] = 1'b1;
    build_expect(0);
    pulse_go(0);
    repeat (2) begin @(posedge clk); #1; end
    total++; if (start[0] !== 1'b1) begin bad++; $display("FAIL hold start_rise got=%b want=1", start[0]); end
    total++; if ({addr[0], data[0]} !== exp_q[0]) begin
      bad++; $display("FAIL hold entry0 got=%h want=%h", {addr[0], data[0]}, exp_q[0]);
    end
    k = $urandom_range(2, 6);
    for (int j = 0; j < k; j++) begin
      @(posedge clk); #1;
      total++; if (start[0] !== 1'b1) begin bad++; $display("FAIL hold held%0d got=%b want=1", j, start[0]); end
    end
    @(negedge clk);
    force_ready[0] = 1'b0;
    @(posedge clk); #1;
    total++; if (start[0] !== 1'b0) begin bad++; $display("FAIL hold drop got=%b want=0", start[0]); end
    repeat ($urandom_range(1, 4)) @(posedge clk);
    @(negedge clk);
    base = rec0.size();
    force_ready[0] = 1'b1;
    mode[0] = 1'b1;
    wait_done(0, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL hold done_timeout got=0 want=1"); end
    total++; if (index_a !== 4'd2) begin bad++; $display("FAIL hold index got=%0d want=2", index_a); end
    total++;
    if (rec0.size() - base != 1) begin
      bad++; $display("FAIL hold tx_count got=%0d want=1", rec0.size() - base);
    end else if (rec0[base] !== exp_q[1]) begin
      bad++; $display("FAIL hold entry1 got=%h want=%h", rec0[base], exp_q[1]);
    end
  endtask

  task automatic test_timeout();
    int hi;
    mode[0] = 1'b0;
    force_ready[0] = 1'b1;
    pulse_go(0);
    hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (start[0]) hi++;
      if (done[0]) break;
    end
    total++; if (hi != 64) begin bad++; $display("FAIL timeout start_cycles got=%0d want=64", hi); end
    total++; if (done[0] !== 1'b1) begin bad++; $display("FAIL timeout done got=%b want=1", done[0]); end
    total++; if (error[0] !== 1'b1) begin bad++; $display("FAIL timeout error got=%b want=1", error[0]); end
    total++; if (start[0] !== 1'b0) begin bad++; $display("FAIL timeout start_end got=%b want=0", start[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL timeout busy got=%b want=0", busy[0]); end
    total++; if (index_a !== 4'd0) begin bad++; $display("FAIL timeout index got=%0d want=0", index_a); end
  endtask

  task automatic test_reset_mid();
    bit found;
    mode[0] = 1'b1;
    pulse_go(0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (busy[0] && !start[0] && !ready[0]) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) begin bad++; $display("FAIL midreset reach_wait got=0 want=1"); end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    test_sequence(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sequence(0, 1'b0);
    test_sequence(1, 1'b0);
    test_stop_hold();
    test_timeout();
    test_reset_mid();
    test_sequence(1, 1'b1);
    test_sequence(1, 1'b0);
    for (int r = 0; r < 4; r++)
      test_sequence(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1);
  end

endmodule
